hdlc_rx_bank_ctrl: RTL and testbench

//  Ping-pong buffer scheduler for the HDLC receive path. Tracks two frame banks in
//  the RX dual-port RAM, steers the receiver into a free bank, gates the receiver when

---
 rtl/hdlc_rx_bank_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hdlc_rx_bank_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_bank_ctrl.sv
// HDLC receive ping-pong bank scheduler with DSP interrupt pulser and EMIF register port.
// Optional HDLC_RX_TIMESTAMP_EN adds a microsecond timestamp per accepted frame.
module hdlc_rx_bank_ctrl #(
    parameter logic [23:0] REG_BASE  = 24'h000100,
    parameter int          INT_WIDTH = 50,
    parameter int          LEN_W     = 9
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             frame_done,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             emif_wen,
    input  logic             emif_ren,
    input  logic [23:0]      emif_addr,
    input  logic [15:0]      emif_wdata,
    output logic [15:0]      emif_rdata,
    output logic             wr_bank,
    output logic             rx_enable,
    output logic             dsp_int
);
    localparam int CNT_W = $clog2(INT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} int_state_t;

    logic [2:0]       fd_sync;
    logic             evt, accept;
    logic [1:0]       bank_full, bank_nx;
    logic             wr_nx;
    logic [LEN_W-1:0] len0, len1;
    logic [15:0]      drop_cnt, drop_nx;
    logic             overrun, ovr_nx;
    logic [1:0]       ctrl, ctrl_nx;
    logic [1:0]       pending;
    logic             in_win, wr_ack, wr_ctrl;
    logic [3:0]       off;
    logic [15:0]      rd_val;
    int_state_t       state, state_nx;
    logic [CNT_W-1:0] tmr, tmr_nx;
    logic             pulse_start;

    // frame_done is asynchronous: two sync flops, third flop for edge detect
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) fd_sync <= '0;
        else        fd_sync <= {fd_sync[1:0], frame_done};
    end
    assign evt    = fd_sync[1] & ~fd_sync[2];
    assign accept = evt & rx_enable;

    assign off     = emif_addr[3:0];
    assign in_win  = (emif_addr[23:4] == REG_BASE[23:4]);
    assign wr_ack  = emif_wen & in_win & (off == 4'd4);
    assign wr_ctrl = emif_wen & in_win & (off == 4'd5);

    // Event is applied first, then ACK, so an ACK sees the post-event bank state
    always_comb begin
        bank_nx = bank_full;
        wr_nx   = wr_bank;
        drop_nx = drop_cnt;
        ovr_nx  = overrun;
        ctrl_nx = ctrl;
        if (accept) begin
            bank_nx[wr_bank] = 1'b1;
            wr_nx            = ~wr_bank;
        end
        if (evt && !rx_enable) begin
            if (drop_cnt != 16'hFFFF) drop_nx = drop_cnt + 16'd1;
            ovr_nx = 1'b1;
        end
        if (wr_ack) begin
            bank_nx = bank_nx & ~emif_wdata[1:0];
            if (emif_wdata[15]) begin
                drop_nx = '0;
                ovr_nx  = 1'b0;
            end
        end
        if (wr_ctrl) ctrl_nx = emif_wdata[1:0];
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rx_enable <= 1'b1;
            drop_cnt  <= '0;
            overrun   <= 1'b0;
            ctrl      <= 2'b11;
            len0      <= '0;
            len1      <= '0;
        end else begin
            bank_full <= bank_nx;
            wr_bank   <= wr_nx;
            // Receiver runs only when globally enabled and its target bank is free
            rx_enable <= ctrl_nx[0] & ~bank_nx[wr_nx];
            drop_cnt  <= drop_nx;
            overrun   <= ovr_nx;
            ctrl      <= ctrl_nx;
            if (accept && !wr_bank) len0 <= frame_len;
            if (accept &&  wr_bank) len1 <= frame_len;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n)                       pending <= '0;
        else if (!ctrl[1])                pending <= '0;
        else if (accept && !pulse_start) begin
            if (pending != 2'b11)         pending <= pending + 2'd1;
        end else if (!accept && pulse_start) pending <= pending - 2'd1;
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmr     <= '0;
            dsp_int <= 1'b0;
        end else begin
            state   <= state_nx;
            tmr     <= tmr_nx;
            dsp_int <= (state_nx == PULSE);
        end
    end

    always_comb begin
        state_nx    = state;
        tmr_nx      = tmr;
        pulse_start = 1'b0;
        case (state)
            IDLE: if (pending != 2'b00 && ctrl[1]) begin
                state_nx    = PULSE;
                tmr_nx      = '0;
                pulse_start = 1'b1;
            end
            PULSE, GAP: begin
                if (tmr == CNT_W'(INT_WIDTH - 1)) begin
                    state_nx = (state == PULSE) ? GAP : IDLE;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef HDLC_RX_TIMESTAMP_EN
    logic [6:0]  pre;
    logic [31:0] us_cnt, ts0, ts1;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            us_cnt <= '0;
            ts0    <= '0;
            ts1    <= '0;
        end else begin
            pre <= (pre == 7'd99) ? 7'd0 : pre + 7'd1;
            if (pre == 7'd99) us_cnt <= us_cnt + 32'd1;
            if (accept && !wr_bank) ts0 <= us_cnt;
            if (accept &&  wr_bank) ts1 <= us_cnt;
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        if (in_win) begin
            case (off)
                4'd0: rd_val = {11'd0, rx_enable, overrun, wr_bank, bank_full};
                4'd1: rd_val = {{(16-LEN_W){1'b0}}, len0};
                4'd2: rd_val = {{(16-LEN_W){1'b0}}, len1};
                4'd3: rd_val = drop_cnt;
                4'd5: rd_val = {14'd0, ctrl};
`ifdef HDLC_RX_TIMESTAMP_EN
                4'd6: rd_val = ts0[31:16];
                4'd7: rd_val = ts0[15:0];
                4'd8: rd_val = ts1[31:16];
                4'd9: rd_val = ts1[15:0];
`endif
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n)        emif_rdata <= '0;
        else if (emif_ren) emif_rdata <= rd_val;
    end

endmodule

// File: tb/tb_hdlc_rx_bank_ctrl.sv
// Scoreboard bench for hdlc_rx_bank_ctrl: directed scenarios plus randomized traffic
// against a transaction-level bank/interrupt model.
module tb_hdlc_rx_bank_ctrl;
    localparam logic [23:0] BASE = 24'h000100;
    localparam int          IW   = 50;

    logic        clk_100m = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_done = 1'b0;
    logic [8:0]  frame_len = '0;
    logic        emif_wen = 1'b0, emif_ren = 1'b0;
    logic [23:0] emif_addr = '0;
    logic [15:0] emif_wdata = '0;
    logic [15:0] emif_rdata;
    logic        wr_bank, rx_enable, dsp_int;

    hdlc_rx_bank_ctrl #(.REG_BASE(BASE), .INT_WIDTH(IW), .LEN_W(9)) dut (
        .clk_100m(clk_100m), .rst_n(rst_n), .frame_done(frame_done), .frame_len(frame_len),
        .emif_wen(emif_wen), .emif_ren(emif_ren), .emif_addr(emif_addr),
        .emif_wdata(emif_wdata), .emif_rdata(emif_rdata), .wr_bank(wr_bank),
        .rx_enable(rx_enable), .dsp_int(dsp_int)
    );

    always #5 clk_100m = ~clk_100m;

    int checks = 0, errors = 0;

    typedef struct { logic [15:0] v; string nm; } rd_exp_t;
    rd_exp_t rd_q[$];
    int      int_q[$];

    // reference model state
    bit       m_full [2];
    int       m_len  [2];
    bit       m_wr, m_rx, m_ovr;
    int       m_drop;
    bit [1:0] m_ctrl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_full = '{0, 0}; m_len = '{0, 0};
        m_wr = 0; m_rx = 1; m_ovr = 0; m_drop = 0; m_ctrl = 2'b11;
    endfunction

    function automatic bit model_frame(input int len);
        if (m_rx) begin
            m_full[m_wr] = 1; m_len[m_wr] = len;
            m_wr = !m_wr;
            if (m_ctrl[1]) int_q.push_back(IW);
            if (m_full[m_wr]) m_rx = 0;
            return 1;
        end
        if (m_drop < 16'hFFFF) m_drop++;
        m_ovr = 1;
        return 0;
    endfunction

    function automatic void model_ack(input logic [15:0] d);
        for (int n = 0; n < 2; n++)
            if (d[n] && m_full[n]) begin
                m_full[n] = 0;
                if (n == int'(m_wr)) m_rx = m_ctrl[0];
            end
        if (d[15]) begin m_drop = 0; m_ovr = 0; end
    endfunction

    function automatic void model_ctrl(input logic [15:0] d);
        m_ctrl = d[1:0];
        m_rx = m_ctrl[0] ? !m_full[m_wr] : 1'b0;
    endfunction

    function automatic logic [15:0] exp_reg(input logic [23:0] a);
        if (a[23:4] != BASE[23:4]) return 16'h0;
        case (a[3:0])
            4'd0: return {11'd0, m_rx, m_ovr, m_wr, m_full[1], m_full[0]};
            4'd1: return 16'(m_len[0]);
            4'd2: return 16'(m_len[1]);
            4'd3: return 16'(m_drop);
            4'd5: return {14'd0, m_ctrl};
            default: return 16'h0;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100m);
    endtask

    task automatic rd_addr(input logic [23:0] a, input string nm);
        rd_exp_t e;
        @(negedge clk_100m);
        emif_ren = 1; emif_addr = a;
        e.v = exp_reg(a); e.nm = nm;
        rd_q.push_back(e);
        @(negedge clk_100m);
        emif_ren = 0;
    endtask

    task automatic rd(input int off, input string nm);
        rd_addr(BASE + 24'(off), nm);
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        @(negedge clk_100m);
        emif_wen = 1; emif_addr = a; emif_wdata = d;
        @(negedge clk_100m);
        emif_wen = 0;
        if (a[23:4] == BASE[23:4] && a[3:0] == 4'd4) model_ack(d);
        if (a[23:4] == BASE[23:4] && a[3:0] == 4'd5) model_ctrl(d);
    endtask

    task automatic chk_pins(input string tag);
        chk({tag, "_rx_enable"}, 32'(rx_enable), 32'(m_rx));
        chk({tag, "_wr_bank"}, 32'(wr_bank), 32'(m_wr));
    endtask

    task automatic send_frame(input int len, output bit acc);
        @(negedge clk_100m);
        frame_len = 9'(len); frame_done = 1;
        tick(3);
        @(negedge clk_100m);
        frame_done = 0;
        tick(6);
        acc = model_frame(len);
    endtask

    // monitor: register reads one cycle after emif_ren, interrupt pulse width and gap
    logic rd_flag = 0;
    always @(posedge clk_100m) rd_flag <= emif_ren;

    int pw = 0, low = 1000;
    always @(negedge clk_100m) begin
        rd_exp_t e;
        if (!rst_n) begin
            pw = 0; low = 1000;
        end else begin
            if (rd_flag) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got %0h expected no read", emif_rdata);
                end else begin
                    e = rd_q.pop_front();
                    chk(e.nm, 32'(emif_rdata), 32'(e.v));
                end
            end
            if (dsp_int) begin
                if (pw == 0) begin
                    checks++;
                    if (low < IW) begin
                        errors++;
                        $display("FAIL int_gap: got %0d low cycles required >= %0d", low, IW);
                    end
                end
                pw++;
            end else begin
                if (pw > 0) begin
                    if (int_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL int_unexpected: got pulse of %0d expected none", pw);
                    end else begin
                        chk("int_width", 32'(pw), 32'(int_q.pop_front()));
                    end
                    pw = 0; low = 0;
                end
                low++;
            end
        end
    end

    initial begin
        bit acc;
        int waitc;
        model_reset();
        tick(3);
        #1 chk("rst_rdata", 32'(emif_rdata), 32'h0);
        chk("rst_dsp_int", 32'(dsp_int), 32'h0);
        chk_pins("rst");
        @(negedge clk_100m) rst_n = 1;
        rd(0, "rst_status"); rd(1, "rst_len0"); rd(2, "rst_len1");
        rd(3, "rst_drop");   rd(5, "rst_ctrl");

        // T1
        send_frame(37, acc);
        chk_pins("t1");
        rd(0, "t1_status"); rd(1, "t1_len0");
        tick(130);
        chk("t1_int_done", 32'(int_q.size()), 32'h0);

        // T2: second fills both banks, third is dropped without a pulse
        send_frame(100, acc);
        chk_pins("t2");
        rd(0, "t2_status"); rd(2, "t2_len1");
        tick(130);
        send_frame(200, acc);
        rd(3, "t2_drop"); rd(0, "t2_status_ovr"); rd(1, "t2_len0_kept");
        tick(130);
        chk("t2_int_done", 32'(int_q.size()), 32'h0);

        // T3
        wr(BASE + 24'd4, 16'h0001);
        chk_pins("t3_ack");
        rd(0, "t3_status");
        wr(BASE + 24'd4, 16'h8000);
        rd(3, "t3_drop"); rd(0, "t3_status_clr");

        // T4: two frames ~10 cycles apart
        wr(BASE + 24'd4, 16'h0003);
        send_frame(11, acc);
        send_frame(22, acc);
        tick(300);
        chk("t4_int_done", 32'(int_q.size()), 32'h0);
        rd(0, "t4_status");

        // T5: event lands on the same edge as an ACK of the other bank
        wr(BASE + 24'd4, 16'h0001);
        @(negedge clk_100m);
        frame_len = 9'd77; frame_done = 1;
        tick(2);
        @(negedge clk_100m);
        emif_wen = 1; emif_addr = BASE + 24'd4; emif_wdata = 16'h0002;
        @(negedge clk_100m);
        emif_wen = 0; frame_done = 0;
        tick(6);
        acc = model_frame(77);
        model_ack(16'h0002);
        chk_pins("t5");
        rd(3, "t5_drop"); rd(0, "t5_status"); rd(1, "t5_len0");
        tick(130);

        // register window / write protection / interrupt disable
        wr(BASE + 24'd0, 16'hFFFF);
        wr({BASE[23:4] + 20'd1, 4'd4}, 16'h8003);
        rd(0, "ro_status");
        rd(9, "unmapped_9"); rd(15, "unmapped_f");
        rd_addr({BASE[23:4] + 20'd1, 4'd0}, "outwin_status");
        wr(BASE + 24'd4, 16'h0003);
        wr(BASE + 24'd5, 16'h0001);
        send_frame(5, acc);
        tick(130);
        wr(BASE + 24'd5, 16'h0003);
        tick(130);
        chk("intdis_done", 32'(int_q.size()), 32'h0);
        wr(BASE + 24'd5, 16'h0002);
        chk_pins("ctrl_off");
        wr(BASE + 24'd5, 16'h0003);
        chk_pins("ctrl_on");
        rd(5, "ctrl_rd");

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                send_frame(int'($urandom_range(0, 511)), acc);
                tick(130);
            end else if (r <= 5) begin
                wr(BASE + 24'd4, {1'($urandom_range(0, 3) == 0), 13'd0, 2'($urandom_range(0, 3))});
            end else if (r == 6) begin
                wr(BASE + 24'd5, {14'd0, 1'b1, 1'($urandom_range(0, 3) != 0)});
            end else begin
                rd(int'($urandom_range(0, 10)), "rand_rd");
            end
            chk_pins("rand");
        end
        tick(130);
        chk("rand_int_done", 32'(int_q.size()), 32'h0);

        // T6: reset in the middle of a pulse
        wr(BASE + 24'd5, 16'h0003);
        wr(BASE + 24'd4, 16'h0003);
        send_frame(33, acc);
        waitc = 0;
        while (!dsp_int && waitc < 20) begin tick(1); waitc++; end
        chk("t6_pulse_seen", 32'(dsp_int), 32'h1);
        tick(5);
        @(negedge clk_100m);
        rst_n = 0;
        #1;
        int_q.delete();
        model_reset();
        chk("t6_dsp_int", 32'(dsp_int), 32'h0);
        chk("t6_rdata", 32'(emif_rdata), 32'h0);
        chk_pins("t6");
        tick(2);
        @(negedge clk_100m) rst_n = 1;
        rd(0, "t6_status"); rd(1, "t6_len0"); rd(5, "t6_ctrl");
        tick(130);
        chk("t6_no_int", 32'(int_q.size()), 32'h0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before 2ms");
        $fatal(1);
    end
endmodule
